// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the load/store unit bus bridge:
//             access-size encodings, the bridge state type and the lane
//             byte-mask helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size, log2 of the number of bytes moved
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_REQ  = 3'd1,
    W_RESP = 3'd2,
    R_REQ  = 3'd3,
    R_DATA = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Byte-lane mask for an access of 2^size bytes starting at lane 'offset'.
  // Computed on the widest (8-lane) bus; narrower buses truncate the result.
  function automatic logic [7:0] size_to_mask(input logic [1:0] size,
                                              input logic [2:0] offset);
    logic [8:0] ones;
    ones = (9'd1 << (4'd1 << size)) - 9'd1;
    return ones[7:0] << offset;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Combinational lane steering for the load/store bridge.
//             Store path: shifts LSB-justified store data onto its byte lanes
//             and builds the lane byte mask.
//             Load path: shifts the bus word down by the lane offset, keeps
//             the accessed bytes and sign- or zero-extends them.
//  Ports    : st_offset/st_size/st_wdata -> st_data/st_mask   (store path)
//             ld_offset/ld_size/ld_sext/ld_rdata -> ld_result  (load path)
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NBYTES = XLEN / 8,
  parameter int OFS_W  = $clog2(NBYTES)
) (
  input  logic [OFS_W-1:0]  st_offset,
  input  logic [1:0]        st_size,
  input  logic [XLEN-1:0]   st_wdata,
  output logic [XLEN-1:0]   st_data,
  output logic [NBYTES-1:0] st_mask,
  input  logic [OFS_W-1:0]  ld_offset,
  input  logic [1:0]        ld_size,
  input  logic              ld_sext,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_result
);

  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] keep;
  logic            sign;

  always_comb begin
    st_mask = NBYTES'(size_to_mask(st_size, 3'(st_offset)));
    st_data = st_wdata << {st_offset, 3'b000};

    ld_shift = ld_rdata >> {ld_offset, 3'b000};

    // An access as wide as the bus keeps every bit; avoid a full-width shift.
    if ((8 << ld_size) >= XLEN) begin
      keep = '1;
    end else begin
      keep = (XLEN'(1) << (8 << ld_size)) - XLEN'(1);
    end

    case (ld_size)
      SZ_B:    sign = ld_shift[7];
      SZ_H:    sign = ld_shift[15];
      SZ_W:    sign = ld_shift[31];
      default: sign = ld_shift[XLEN-1];
    endcase

    ld_result = (ld_shift & keep) | ((ld_sext && sign) ? ~keep : '0);
  end

endmodule
`default_nettype wire

// File: rtl/lsu_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_axi_bridge
//  Purpose  : Load/store unit between the execute stage and a ready/valid
//             data-memory port. Accepts one request at a time, lane-aligns
//             stores, extends loads, rejects misaligned/illegal accesses
//             without touching the bus, and holds the pipeline via stall.
//  Ports    : clk, rst (async, active high)
//             req_*            request from execute (valid/ready handshake)
//             resp_*           one-cycle completion pulse, data and error
//             stall            pipeline hold while a transaction is in flight
//             w_* / r_*        write and read channels toward memory
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_axi_bridge
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int NBYTES = XLEN / 8,
  parameter int OFS_W  = $clog2(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              w_valid_i,
  input  logic              w_ready_o,
  output logic [ADDR_W-1:0] w_addr_i,
  output logic [XLEN-1:0]   w_data_i,
  output logic [NBYTES-1:0] w_mask_i,
  input  logic              w_valid_o,
  output logic              w_ready_i,
  output logic              r_valid_i,
  input  logic              r_ready_o,
  output logic [ADDR_W-1:0] r_addr_i,
  output logic [NBYTES-1:0] r_size_i,
  input  logic [XLEN-1:0]   r_data_o,
  input  logic              r_data_valid,
  output logic              r_data_ready
);

  state_t            state;
  logic [OFS_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [XLEN-1:0]   st_data;
  logic [NBYTES-1:0] st_mask;
  logic [XLEN-1:0]   ld_result;
  logic              misaligned;
  logic              illegal;

  // Store lanes are computed from the live request so they can be registered
  // at acceptance; load extraction uses the fields latched at acceptance.
  lsu_lane_align #(
    .XLEN   (XLEN),
    .NBYTES (NBYTES),
    .OFS_W  (OFS_W)
  ) u_align (
    .st_offset (req_addr[OFS_W-1:0]),
    .st_size   (req_size),
    .st_wdata  (req_wdata),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .ld_offset (off_q),
    .ld_size   (size_q),
    .ld_sext   (sext_q),
    .ld_rdata  (r_data_o),
    .ld_result (ld_result)
  );

  always_comb begin
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    illegal = (req_size == SZ_D) && (XLEN < 64);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      off_q        <= '0;
      size_q       <= SZ_B;
      sext_q       <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      stall        <= 1'b0;
      w_valid_i    <= 1'b0;
      w_addr_i     <= '0;
      w_data_i     <= '0;
      w_mask_i     <= '0;
      w_ready_i    <= 1'b0;
      r_valid_i    <= 1'b0;
      r_addr_i     <= '0;
      r_size_i     <= '0;
      r_data_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_addr[OFS_W-1:0];
            size_q    <= req_size;
            sext_q    <= req_sext;
            if (misaligned || illegal) begin
              // Rejected without any bus activity; respond next cycle.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_wen) begin
              state     <= W_REQ;
              stall     <= 1'b1;
              w_valid_i <= 1'b1;
              w_addr_i  <= req_addr;
              w_data_i  <= st_data;
              w_mask_i  <= st_mask;
            end else begin
              state     <= R_REQ;
              stall     <= 1'b1;
              r_valid_i <= 1'b1;
              r_addr_i  <= req_addr;
              r_size_i  <= st_mask;
            end
          end
        end
        W_REQ: begin
          if (w_ready_o) begin
            state     <= W_RESP;
            w_valid_i <= 1'b0;
            w_ready_i <= 1'b1;
          end
        end
        W_RESP: begin
          if (w_valid_o) begin
            state      <= RESP;
            w_ready_i  <= 1'b0;
            stall      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        R_REQ: begin
          if (r_ready_o) begin
            state        <= R_DATA;
            r_valid_i    <= 1'b0;
            r_data_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_data_valid) begin
            state        <= RESP;
            r_data_ready <= 1'b0;
            stall        <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b0;
            resp_rdata   <= ld_result;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_axi_bridge
//  Purpose  : Self-checking bench for lsu_axi_bridge. A 64-bit instance is
//             driven with directed and random loads/stores against a
//             programmable-wait memory slave; a 32-bit instance with an
//             always-ready slave covers the narrow-bus cases.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_axi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        req_valid, req_ready, req_wen, req_sext;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err, stall;
  logic [63:0] resp_rdata;
  logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
  logic [63:0] w_addr_i, w_data_i;
  logic [7:0]  w_mask_i, r_size_i;
  logic        r_valid_i, r_ready_o, r_data_valid, r_data_ready;
  logic [63:0] r_addr_i, r_data_o;

  // 32-bit instance
  logic        s_req_valid, s_req_ready, s_req_wen, s_req_sext;
  logic [31:0] s_req_addr, s_req_wdata;
  logic [1:0]  s_req_size;
  logic        s_resp_valid, s_resp_err, s_stall;
  logic [31:0] s_resp_rdata;
  logic        s_w_valid_i, s_w_ready_o, s_w_valid_o, s_w_ready_i;
  logic [31:0] s_w_addr_i, s_w_data_i;
  logic [3:0]  s_w_mask_i, s_r_size_i;
  logic        s_r_valid_i, s_r_ready_o, s_r_data_valid, s_r_data_ready;
  logic [31:0] s_r_addr_i, s_r_data_o;

  int tests = 0;
  int fails = 0;

  lsu_axi_bridge #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_sext(req_sext),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .w_mask_i(w_mask_i), .w_valid_o(w_valid_o),
    .w_ready_i(w_ready_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_addr_i(r_addr_i),
    .r_size_i(r_size_i), .r_data_o(r_data_o), .r_data_valid(r_data_valid),
    .r_data_ready(r_data_ready)
  );

  lsu_axi_bridge #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wen(s_req_wen),
    .req_addr(s_req_addr), .req_size(s_req_size), .req_sext(s_req_sext),
    .req_wdata(s_req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
    .stall(s_stall),
    .w_valid_i(s_w_valid_i), .w_ready_o(s_w_ready_o), .w_addr_i(s_w_addr_i),
    .w_data_i(s_w_data_i), .w_mask_i(s_w_mask_i), .w_valid_o(s_w_valid_o),
    .w_ready_i(s_w_ready_i),
    .r_valid_i(s_r_valid_i), .r_ready_o(s_r_ready_o), .r_addr_i(s_r_addr_i),
    .r_size_i(s_r_size_i), .r_data_o(s_r_data_o), .r_data_valid(s_r_data_valid),
    .r_data_ready(s_r_data_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access on the 64-bit instance. wd1/wd2 are the slave's wait cycles
  // before accepting the request and before returning the response.
  task automatic run_op(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                        input bit sext, input logic [63:0] wdata, input logic [63:0] rdata,
                        input int wd1, input int wd2);
    int          nb, off, m, lat, exp_lat, c1, c2;
    bit          err, done;
    logic [7:0]  exp_mask;
    logic [63:0] exp_data, exp_r, v, keep;

    // Reference behaviour from the access rules
    nb       = 1 << size;
    off      = int'(addr[2:0]);
    err      = (addr % nb) != 0;
    m        = ((1 << nb) - 1) << off;
    exp_mask = m[7:0];
    exp_data = wdata << (8 * off);
    v        = rdata >> (8 * off);
    if (nb < 8) begin
      keep = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & keep;
      if (sext && v[8*nb-1]) v = v | ~keep;
    end
    exp_r   = (err || wen) ? 64'd0 : v;
    exp_lat = err ? 1 : 3 + wd1 + wd2;

    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_size = size;
    req_sext = sext; req_wdata = wdata;
    @(posedge clk); #1;
    // Fields must be ignored after acceptance
    req_valid = 0; req_wen = ~wen; req_addr = {$urandom, $urandom};
    req_size = 2'($urandom); req_sext = ~sext; req_wdata = {$urandom, $urandom};

    c1 = 0; c2 = 0; lat = 0; done = 0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (err) chk("no_bus", {62'd0, w_valid_i, r_valid_i}, 0);
      if (w_valid_i) begin
        chk("w_addr", w_addr_i, addr);
        chk("w_data", w_data_i, exp_data);
        chk("w_mask", w_mask_i, exp_mask);
        w_ready_o = (c1 >= wd1); c1++;
      end else w_ready_o = 0;
      if (r_valid_i) begin
        chk("r_addr", r_addr_i, addr);
        chk("r_size", r_size_i, exp_mask);
        r_ready_o = (c1 >= wd1); c1++;
      end else r_ready_o = 0;
      if (w_ready_i) begin
        w_valid_o = (c2 >= wd2); c2++;
      end else w_valid_o = 0;
      if (r_data_ready) begin
        r_data_valid = (c2 >= wd2); c2++;
        r_data_o = r_data_valid ? rdata : {$urandom, $urandom};
      end else r_data_valid = 0;
      if (resp_valid) begin
        lat = cyc; done = 1;
        chk("resp_err", resp_err, err);
        chk("resp_rdata", resp_rdata, exp_r);
        chk("stall_resp", stall, 0);
        chk("ready_resp", req_ready, 0);
      end else begin
        chk("stall_busy", stall, 1);
      end
    end
    w_ready_o = 0; w_valid_o = 0; r_ready_o = 0; r_data_valid = 0;
    chk("latency", lat, exp_lat);
    @(posedge clk); #1;
    chk("resp_pulse", resp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  // One access on the 32-bit instance (slave always ready/valid)
  task automatic run32(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                       output logic got_err, output logic [3:0] mask,
                       output logic [31:0] data, output bit saw_w, output int lat);
    s_req_valid = 1; s_req_wen = 1; s_req_addr = addr; s_req_size = size;
    s_req_sext = 0; s_req_wdata = wdata;
    got_err = 0; mask = 0; data = 0; saw_w = 0; lat = 0;
    @(posedge clk); #1;
    s_req_valid = 0;
    for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (s_w_valid_i) begin saw_w = 1; mask = s_w_mask_i; data = s_w_data_i; end
      if (s_resp_valid) begin lat = cyc; got_err = s_resp_err; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic        e32;
    logic [3:0]  m32;
    logic [31:0] d32;
    bit          sw32;
    int          l32;
    int          n;
    logic [63:0] a;
    logic [1:0]  sz;

    rst = 1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_sext = 0; req_wdata = 0;
    w_ready_o = 0; w_valid_o = 0; r_ready_o = 0; r_data_valid = 0; r_data_o = 0;
    s_req_valid = 0; s_req_wen = 0; s_req_addr = 0; s_req_size = 0; s_req_sext = 0;
    s_req_wdata = 0;
    s_w_ready_o = 1; s_w_valid_o = 1; s_r_ready_o = 1; s_r_data_valid = 1; s_r_data_o = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {resp_valid, resp_err, stall, w_valid_i, w_ready_i, r_valid_i, r_data_ready}, 0);
    chk("rst_rdata", resp_rdata, 0);
    rst = 0;
    @(posedge clk); #1;

    // Narrow bus: doubleword is illegal, halfword store on upper lanes
    run32(32'h0000_0000, 2'd3, 32'h1234_5678, e32, m32, d32, sw32, l32);
    chk("x32_d_err", e32, 1);
    chk("x32_d_nobus", sw32, 0);
    chk("x32_d_lat", l32, 1);
    run32(32'h0000_0002, 2'd1, 32'h0000_5A5A, e32, m32, d32, sw32, l32);
    chk("x32_h_err", e32, 0);
    chk("x32_h_mask", m32, 4'hC);
    chk("x32_h_data", d32, 32'h5A5A_0000);
    chk("x32_h_lat", l32, 3);

    // Directed 64-bit cases
    run_op(1, 64'h8000_0003, 2'd0, 0, 64'hAB, 64'd0, 0, 0);
    run_op(0, 64'h8000_1004, 2'd2, 1, 64'd0, 64'h8123_4567_0000_0000, 0, 0);
    run_op(0, 64'h8000_1004, 2'd2, 0, 64'd0, 64'h8123_4567_0000_0000, 0, 0);
    run_op(0, 64'h8000_0001, 2'd1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op(1, 64'h8000_0010, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 3, 2);

    // Reset while waiting for read data abandons the load
    req_valid = 1; req_wen = 0; req_addr = 64'h8000_2000; req_size = 2'd3; req_sext = 0;
    @(posedge clk); #1;
    req_valid = 0; r_ready_o = 1;
    n = 0;
    while (!r_data_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("rdata_wait_reached", r_data_ready, 1);
    rst = 1; #1;
    chk("midrst_outs", {resp_valid, stall, w_valid_i, w_ready_i, r_valid_i, r_data_ready}, 0);
    chk("midrst_ready", req_ready, 1);
    r_ready_o = 0; r_data_valid = 1; r_data_o = 64'h1;
    repeat (2) begin @(posedge clk); #1; chk("midrst_noresp", resp_valid, 0); end
    r_data_valid = 0;
    rst = 0;
    @(posedge clk); #1;
    run_op(0, 64'h8000_2006, 2'd1, 1, 64'd0, 64'h8001_0000_0000_0000, 1, 1);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      a  = {$urandom, $urandom};
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      run_op(1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
